cursor_gen: RTL and testbench

- Parametrised text-mode cursor generator for the CRTC pixel pipeline.
- Per character load, decides whether the cursor overlays the current character cell and scanline, then delays that decision to line up with the attribute/font fetch.
- Contains the blink-rate frame counter. Adds selectable cursor modes (off / steady / slow blink / fast blink) and split (wrap-around) scanline ranges.
- Latches the cursor configuration once per frame so mid-frame CPU writes cannot tear the cursor.

---
 rtl/cursor_gen.sv | 127 ++++++++++++
 tb/tb_cursor_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_gen.sv
// Text-mode cursor generator: per-frame config shadow, blink-rate frame counter and a
// fixed-latency compare pipeline aligned to the attribute/font fetch.
module cursor_gen #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned ROW_W        = 4,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned PIPE_DELAY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              char_load,
  input  logic [ADDR_W-1:0] vram_address,
  input  logic [ROW_W-1:0]  scanline,
  input  logic [ADDR_W-1:0] cfg_match_address,
  input  logic [1:0]        cfg_mode,
  input  logic [ROW_W-1:0]  cfg_start_scanline,
  input  logic [ROW_W-1:0]  cfg_end_scanline,
  output logic              cursor_valid,
  output logic              cursor_active,
  output logic              blink_state
);

  localparam int unsigned CntW = $clog2(BLINK_FRAMES);
  localparam logic [CntW-1:0] SlowLast = CntW'(BLINK_FRAMES - 1);
  localparam logic [CntW-1:0] FastLast = CntW'(BLINK_FRAMES / 2 - 1);

  typedef enum logic [1:0] {
    ModeOff    = 2'b00,
    ModeSteady = 2'b01,
    ModeSlow   = 2'b10,
    ModeFast   = 2'b11
  } mode_e;

  logic [ADDR_W-1:0]     match_q, match_d;
  mode_e                 mode_q, mode_d;
  logic [ROW_W-1:0]      start_q, start_d;
  logic [ROW_W-1:0]      end_q, end_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  blink_q, blink_d;
  logic [CntW-1:0]       blink_last;
  logic                  win_hit;
  logic                  hit;
  logic [PIPE_DELAY-1:0] valid_q, valid_d;
  logic [PIPE_DELAY-1:0] hit_q, hit_d;

  assign blink_last = (mode_q == ModeFast) ? FastLast : SlowLast;

  // Shadow capture and blink counter both act only on frame_start, using pre-edge shadow mode.
  always_comb begin
    match_d = match_q;
    mode_d  = mode_q;
    start_d = start_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (frame_start) begin
      match_d = cfg_match_address;
      mode_d  = mode_e'(cfg_mode);
      start_d = cfg_start_scanline;
      end_d   = cfg_end_scanline;
      case (mode_q)
        ModeSlow, ModeFast: begin
          // >= so a slow->fast switch with a large count rolls over on the next frame.
          if (cnt_q >= blink_last) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          blink_d = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    if (start_q <= end_q) begin
      win_hit = (scanline >= start_q) && (scanline <= end_q);
    end else begin
      win_hit = (scanline >= start_q) || (scanline <= end_q);
    end
    hit = char_load && (vram_address == match_q) && win_hit && (mode_q != ModeOff) &&
          ((mode_q == ModeSteady) || blink_q);
  end

  always_comb begin
    valid_d    = '0;
    hit_d      = '0;
    valid_d[0] = char_load;
    hit_d[0]   = hit;
    for (int i = 1; i < int'(PIPE_DELAY); i++) begin
      valid_d[i] = valid_q[i-1];
      hit_d[i]   = hit_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= '0;
      mode_q  <= ModeOff;
      start_q <= '0;
      end_q   <= '1;
      cnt_q   <= '0;
      blink_q <= 1'b1;
      valid_q <= '0;
      hit_q   <= '0;
    end else begin
      match_q <= match_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
    end
  end

  assign cursor_valid  = valid_q[PIPE_DELAY-1];
  assign cursor_active = valid_q[PIPE_DELAY-1] & hit_q[PIPE_DELAY-1];
  assign blink_state   = blink_q;

endmodule

// File: tb/tb_cursor_gen.sv
// Directed bench for cursor_gen: loads push expected overlay results to a scoreboard that a
// negedge monitor pops when the delayed output is due.
module tb_cursor_gen;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned LAT    = 2;

  logic              clk;
  logic              rst_n;
  logic              frame_start;
  logic              char_load;
  logic [ADDR_W-1:0] vram_address;
  logic [ROW_W-1:0]  scanline;
  logic [ADDR_W-1:0] cfg_match_address;
  logic [1:0]        cfg_mode;
  logic [ROW_W-1:0]  cfg_start_scanline;
  logic [ROW_W-1:0]  cfg_end_scanline;
  logic              cursor_valid;
  logic              cursor_active;
  logic              blink_state;

  typedef struct {
    logic        act;
    int unsigned due;
  } sb_t;

  sb_t         sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  cursor_gen #(
    .ADDR_W      (ADDR_W),
    .ROW_W       (ROW_W),
    .BLINK_FRAMES(16),
    .PIPE_DELAY  (LAT)
  ) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_start       (frame_start),
    .char_load         (char_load),
    .vram_address      (vram_address),
    .scanline          (scanline),
    .cfg_match_address (cfg_match_address),
    .cfg_mode          (cfg_mode),
    .cfg_start_scanline(cfg_start_scanline),
    .cfg_end_scanline  (cfg_end_scanline),
    .cursor_valid      (cursor_valid),
    .cursor_active     (cursor_active),
    .blink_state       (blink_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: an output is due exactly LAT cycles after its load; otherwise valid must be low.
  always @(negedge clk) begin
    sb_t e;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("valid_on_time", int'(cursor_valid), 1);
      chk("active", int'(cursor_active), int'(e.act));
    end else begin
      chk("no_valid", int'(cursor_valid), 0);
    end
    chk("active_qualified", int'(cursor_active & ~cursor_valid), 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    char_load   = 1'b0;
    frame_start = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_cfg(input logic [ADDR_W-1:0] m, input logic [1:0] md,
                         input logic [ROW_W-1:0] s, input logic [ROW_W-1:0] e);
    cfg_match_address  = m;
    cfg_mode           = md;
    cfg_start_scanline = s;
    cfg_end_scanline   = e;
  endtask

  task automatic frame(input logic [ADDR_W-1:0] m, input logic [1:0] md,
                       input logic [ROW_W-1:0] s, input logic [ROW_W-1:0] e);
    set_cfg(m, md, s, e);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Drives one load for one cycle; consecutive calls give back-to-back loads.
  task automatic load(input logic [ADDR_W-1:0] a, input logic [ROW_W-1:0] sl, input logic exp);
    sb_t e;
    char_load    = 1'b1;
    vram_address = a;
    scanline     = sl;
    e.act        = exp;
    e.due        = cyc + LAT;
    sb.push_back(e);
    tick();
    char_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b1;
    frame_start  = 1'b0;
    char_load    = 1'b0;
    vram_address = '0;
    scanline     = '0;
    set_cfg('0, 2'b00, '0, '0);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid", int'(cursor_valid), 0);
    chk("reset_active", int'(cursor_active), 0);
    chk("reset_blink", int'(blink_state), 1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset shadow is mode off even though match 0 and the full window would hit.
    load(11'h000, 4'd15, 1'b0);
    idle(3);

    // Basic window S=13, E=14.
    frame(11'h123, 2'b01, 4'd13, 4'd14);
    load(11'h123, 4'd12, 1'b0);
    load(11'h123, 4'd13, 1'b1);
    load(11'h123, 4'd14, 1'b1);
    load(11'h123, 4'd15, 1'b0);
    idle(3);

    // Mid-frame cfg write has no effect until next frame_start.
    cfg_match_address = 11'h124;
    load(11'h124, 4'd13, 1'b0);
    load(11'h123, 4'd13, 1'b1);
    idle(2);
    frame(11'h124, 2'b01, 4'd13, 4'd14);
    load(11'h124, 4'd13, 1'b1);
    load(11'h123, 4'd13, 1'b0);
    idle(3);

    // Slow blink: capture pulse runs under steady mode, then 40 counted pulses.
    frame(11'h124, 2'b10, 4'd13, 4'd14);
    chk("blink_enter_slow", int'(blink_state), 1);
    for (int p = 1; p <= 40; p++) begin
      frame(11'h124, 2'b10, 4'd13, 4'd14);
      chk("blink_slow", int'(blink_state), (p >= 16 && p < 32) ? 0 : 1);
      if (p == 10) load(11'h124, 4'd13, 1'b1);
      if (p == 20) load(11'h124, 4'd14, 1'b0);
    end
    // Counter is now 8; switching to fast still counts under the slow limit once (-> 9),
    // then 9 exceeds the fast limit so the next pulse rolls over and toggles.
    frame(11'h124, 2'b11, 4'd13, 4'd14);
    chk("blink_switch_fast", int'(blink_state), 1);
    frame(11'h124, 2'b11, 4'd13, 4'd14);
    chk("blink_fast_rollover", int'(blink_state), 0);
    for (int q = 1; q <= 16; q++) begin
      frame(11'h124, 2'b11, 4'd13, 4'd14);
      chk("blink_fast", int'(blink_state), (q >= 8 && q < 16) ? 1 : 0);
      if (q == 3) load(11'h124, 4'd13, 1'b0);
      if (q == 9) load(11'h124, 4'd13, 1'b1);
    end
    // Back to steady: first pulse still counts under fast mode, next forces visible.
    frame(11'h124, 2'b01, 4'd13, 4'd14);
    chk("blink_leave_fast", int'(blink_state), 0);
    frame(11'h124, 2'b01, 4'd13, 4'd14);
    chk("blink_forced_on", int'(blink_state), 1);
    idle(2);

    // Split cursor S=14, E=1, then single-line S=E=5; full-throughput loads.
    frame(11'h124, 2'b01, 4'd14, 4'd1);
    for (int sl = 0; sl < 16; sl++) begin
      load(11'h124, 4'(sl), (sl <= 1 || sl >= 14));
    end
    frame(11'h124, 2'b01, 4'd5, 4'd5);
    for (int sl = 0; sl < 16; sl++) begin
      load(11'h124, 4'(sl), (sl == 5));
    end
    load(11'h125, 4'd5, 1'b0);
    idle(3);

    // Simultaneous frame_start + load uses pre-edge (steady) shadow.
    set_cfg(11'h124, 2'b00, 4'd5, 4'd5);
    frame_start = 1'b1;
    load(11'h124, 4'd5, 1'b1);
    frame_start = 1'b0;
    load(11'h124, 4'd5, 1'b0);
    idle(3);

    // Reset mid-stream drops outputs asynchronously and reverts shadow to off.
    frame(11'h124, 2'b01, 4'd0, 4'd15);
    for (int i = 0; i < 5; i++) load(11'h124, 4'(i), 1'b1);
    char_load = 1'b1;
    chk("pre_reset_valid", int'(cursor_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", int'(cursor_valid), 0);
    chk("async_reset_active", int'(cursor_active), 0);
    sb.delete();
    char_load = 1'b0;
    idle(2);
    rst_n = 1'b1;
    load(11'h124, 4'd3, 1'b0);
    load(11'h124, 4'd4, 1'b0);
    load(11'h000, 4'd15, 1'b0);
    idle(2);
    frame(11'h124, 2'b01, 4'd0, 4'd15);
    load(11'h124, 4'd4, 1'b1);
    idle(4);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
